// File: rtl/axi_sram_responder.sv
// AXI4 responder over a single-ported-per-direction word RAM.
// Independent read and write burst engines share one storage array.
module axi_sram_responder #(
    parameter int IDX_W = 12,
    parameter int ID_W  = 4
) (
    input  logic            aclk,
    input  logic            aresetn,
    input  logic [ID_W-1:0] arid,
    input  logic [31:0]     araddr,
    input  logic [7:0]      arlen,
    input  logic [2:0]      arsize,
    input  logic [1:0]      arburst,
    input  logic [1:0]      arlock,
    input  logic [3:0]      arcache,
    input  logic [2:0]      arprot,
    input  logic            arvalid,
    output logic            arready,
    output logic [ID_W-1:0] rid,
    output logic [31:0]     rdata,
    output logic [1:0]      rresp,
    output logic            rlast,
    output logic            rvalid,
    input  logic            rready,
    input  logic [ID_W-1:0] awid,
    input  logic [31:0]     awaddr,
    input  logic [7:0]      awlen,
    input  logic [2:0]      awsize,
    input  logic [1:0]      awburst,
    input  logic [1:0]      awlock,
    input  logic [3:0]      awcache,
    input  logic [2:0]      awprot,
    input  logic            awvalid,
    output logic            awready,
    input  logic [31:0]     wdata,
    input  logic [3:0]      wstrb,
    input  logic            wlast,
    input  logic            wvalid,
    output logic            wready,
    output logic [ID_W-1:0] bid,
    output logic [1:0]      bresp,
    output logic            bvalid,
    input  logic            bready
);

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] FIXED  = 2'b00;
    localparam logic [1:0] WRAP   = 2'b10;

    typedef enum logic {R_IDLE, R_BURST} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

    function automatic logic burst_err(
        input logic [2:0] sz,
        input logic [7:0] ln,
        input logic [1:0] bt
    );
        logic bad_wrap;
        bad_wrap = (bt == WRAP) && !(ln == 8'd1 || ln == 8'd3 ||
                                     ln == 8'd7 || ln == 8'd15);
        burst_err = (bt == 2'b11) || (sz > 3'd2) || bad_wrap;
    endfunction

    // Illegal bursts fall back to INCR stepping.
    function automatic logic [31:0] next_addr(
        input logic [31:0] a,
        input logic [2:0]  sz,
        input logic [7:0]  ln,
        input logic [1:0]  bt,
        input logic        er
    );
        logic [31:0] step;
        logic [31:0] incr;
        logic [31:0] wmask;
        step  = 32'd1 << sz;
        incr  = (a & ~(step - 32'd1)) + step;
        wmask = step * ({24'd0, ln} + 32'd1) - 32'd1;
        next_addr = incr;
        if (!er && bt == FIXED)
            next_addr = a;
        else if (!er && bt == WRAP)
            next_addr = (a & ~wmask) | (incr & wmask);
    endfunction

    logic [31:0] mem [2**IDX_W];

    logic rdy_q;
    logic unused_sideband;
    assign unused_sideband = ^{arlock, arcache, arprot,
                               awlock, awcache, awprot};

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) rdy_q <= 1'b0;
        else          rdy_q <= 1'b1;
    end

    // ---------------- read channel ----------------
    r_state_t        r_state, r_next;
    logic [ID_W-1:0] r_id;
    logic [31:0]     r_addr, r_addr_nxt;
    logic [7:0]      r_len, r_beat;
    logic [2:0]      r_size;
    logic [1:0]      r_burst;
    logic            r_err;
    logic            ar_hs, r_adv, rd_en;
    logic [IDX_W-1:0] rd_idx;

    assign r_addr_nxt = next_addr(r_addr, r_size, r_len, r_burst, r_err);
    assign rvalid = (r_state == R_BURST);
    assign rlast  = rvalid && (r_beat == r_len);
    assign rid    = r_id;
    assign rresp  = r_err ? SLVERR : OKAY;

    always_comb begin
        r_next  = r_state;
        arready = 1'b0;
        ar_hs   = 1'b0;
        r_adv   = 1'b0;
        rd_en   = 1'b0;
        rd_idx  = araddr[IDX_W+1:2];
        unique case (r_state)
            R_IDLE: begin
                arready = rdy_q;
                if (arvalid && rdy_q) begin
                    ar_hs  = 1'b1;
                    rd_en  = 1'b1;
                    r_next = R_BURST;
                end
            end
            R_BURST: begin
                if (rready) begin
                    if (rlast) begin
                        r_next = R_IDLE;
                    end else begin
                        r_adv  = 1'b1;
                        rd_en  = 1'b1;
                        rd_idx = r_addr_nxt[IDX_W+1:2];
                    end
                end
            end
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state <= R_IDLE;
            r_id    <= '0;
            r_addr  <= '0;
            r_len   <= '0;
            r_beat  <= '0;
            r_size  <= '0;
            r_burst <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= r_next;
            if (ar_hs) begin
                r_id    <= arid;
                r_addr  <= araddr;
                r_len   <= arlen;
                r_size  <= arsize;
                r_burst <= arburst;
                r_err   <= burst_err(arsize, arlen, arburst);
                r_beat  <= '0;
            end else if (r_adv) begin
                r_addr <= r_addr_nxt;
                r_beat <= r_beat + 8'd1;
            end
        end
    end

    // Registered read port; the array read sees pre-write contents.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn)   rdata <= '0;
        else if (rd_en) rdata <= mem[rd_idx];
    end

    // ---------------- write channel ----------------
    w_state_t        w_state, w_next;
    logic [ID_W-1:0] w_id;
    logic [31:0]     w_addr, w_addr_nxt;
    logic [7:0]      w_len, w_beat;
    logic [2:0]      w_size;
    logic [1:0]      w_burst;
    logic            w_err, w_bad;
    logic            aw_hs, w_hs;
    logic            w_end;

    assign w_end      = (w_beat == w_len);
    assign w_addr_nxt = next_addr(w_addr, w_size, w_len, w_burst, w_err);
    assign bid   = w_id;
    assign bresp = w_bad ? SLVERR : OKAY;

    always_comb begin
        w_next  = w_state;
        awready = 1'b0;
        wready  = 1'b0;
        bvalid  = 1'b0;
        aw_hs   = 1'b0;
        w_hs    = 1'b0;
        unique case (w_state)
            W_IDLE: begin
                awready = rdy_q;
                if (awvalid && rdy_q) begin
                    aw_hs  = 1'b1;
                    w_next = W_DATA;
                end
            end
            W_DATA: begin
                wready = 1'b1;
                if (wvalid) begin
                    w_hs = 1'b1;
                    if (w_end) w_next = W_RESP;
                end
            end
            W_RESP: begin
                bvalid = 1'b1;
                if (bready) w_next = W_IDLE;
            end
            default: w_next = W_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            w_state <= W_IDLE;
            w_id    <= '0;
            w_addr  <= '0;
            w_len   <= '0;
            w_beat  <= '0;
            w_size  <= '0;
            w_burst <= '0;
            w_err   <= 1'b0;
            w_bad   <= 1'b0;
        end else begin
            w_state <= w_next;
            if (aw_hs) begin
                w_id    <= awid;
                w_addr  <= awaddr;
                w_len   <= awlen;
                w_size  <= awsize;
                w_burst <= awburst;
                w_err   <= burst_err(awsize, awlen, awburst);
                w_bad   <= burst_err(awsize, awlen, awburst);
                w_beat  <= '0;
            end else if (w_hs) begin
                w_bad  <= w_bad | (wlast != w_end);
                w_addr <= w_addr_nxt;
                w_beat <= w_beat + 8'd1;
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (w_hs) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb[b])
                    mem[w_addr[IDX_W+1:2]][b*8 +: 8] <= wdata[b*8 +: 8];
            end
        end
    end

endmodule

// File: tb/tb_axi_sram_responder.sv
// Directed bench for axi_sram_responder.
// Inputs change on the falling edge; outputs are sampled there too.
module tb_axi_sram_responder;

    localparam int IDX_W = 12;
    localparam int ID_W  = 4;

    logic            aclk = 1'b0;
    logic            aresetn;
    logic [ID_W-1:0] arid, awid, rid, bid;
    logic [31:0]     araddr, awaddr, rdata, wdata;
    logic [7:0]      arlen, awlen;
    logic [2:0]      arsize, awsize, arprot, awprot;
    logic [1:0]      arburst, awburst, arlock, awlock;
    logic [3:0]      arcache, awcache, wstrb;
    logic [1:0]      rresp, bresp;
    logic            arvalid, arready, rlast, rvalid, rready;
    logic            awvalid, awready, wlast, wvalid, wready;
    logic            bvalid, bready;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] ev [16];

    always #5 aclk = ~aclk;

    axi_sram_responder #(.IDX_W(IDX_W), .ID_W(ID_W)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .arid(arid), .araddr(araddr), .arlen(arlen),
        .arsize(arsize), .arburst(arburst), .arlock(arlock),
        .arcache(arcache), .arprot(arprot),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp),
        .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen),
        .awsize(awsize), .awburst(awburst), .awlock(awlock),
        .awcache(awcache), .awprot(awprot),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic ar_send(input logic [3:0] id, input logic [31:0] a,
                           input logic [7:0] len, input logic [2:0] sz,
                           input logic [1:0] bt);
        logic ok;
        ok = 1'b0;
        arid = id; araddr = a; arlen = len; arsize = sz; arburst = bt;
        arvalid = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin
            ok = arready;
            @(negedge aclk);
        end
        arvalid = 1'b0;
        chk("ar_handshake", {31'd0, ok}, 32'd1);
    endtask

    task automatic aw_send(input logic [3:0] id, input logic [31:0] a,
                           input logic [7:0] len, input logic [2:0] sz,
                           input logic [1:0] bt);
        logic ok;
        ok = 1'b0;
        awid = id; awaddr = a; awlen = len; awsize = sz; awburst = bt;
        awvalid = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin
            ok = awready;
            @(negedge aclk);
        end
        awvalid = 1'b0;
        chk("aw_handshake", {31'd0, ok}, 32'd1);
    endtask

    task automatic w_send(input logic [31:0] d, input logic [3:0] s,
                          input logic l);
        logic ok;
        ok = 1'b0;
        wdata = d; wstrb = s; wlast = l; wvalid = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin
            ok = wready;
            @(negedge aclk);
        end
        wvalid = 1'b0; wlast = 1'b0;
        chk("w_handshake", {31'd0, ok}, 32'd1);
    endtask

    task automatic b_get(input string tag, input logic [3:0] id,
                         input logic [1:0] resp);
        logic got;
        got = 1'b0;
        bready = 1'b1;
        for (int i = 0; i < 50 && !got; i++) begin
            if (bvalid) begin
                got = 1'b1;
                chk({tag, "_bid_bresp"}, {26'd0, bid, bresp},
                    {26'd0, id, resp});
            end
            @(negedge aclk);
        end
        bready = 1'b0;
        chk({tag, "_bvalid_seen"}, {31'd0, got}, 32'd1);
        chk({tag, "_bvalid_drop"}, {31'd0, bvalid}, 32'd0);
    endtask

    task automatic r_get(input string tag, input int n,
                         input logic [3:0] id, input logic [1:0] resp,
                         input logic [3:0] rpat);
        int got, c0, cl;
        logic stalled;
        logic [31:0] hd;
        logic hl;
        got = 0; c0 = 0; cl = 0; stalled = 1'b0; hd = '0; hl = 1'b0;
        for (int c = 0; c < 200 && got < n; c++) begin
            rready = rpat[c % 4];
            if (stalled) begin
                chk($sformatf("%s_hold_data", tag), rdata, hd);
                chk($sformatf("%s_hold_last", tag),
                    {31'd0, rlast}, {31'd0, hl});
                stalled = 1'b0;
            end
            if (rvalid && rready) begin
                chk($sformatf("%s_b%0d_data", tag, got), rdata, ev[got]);
                chk($sformatf("%s_b%0d_ctl", tag, got),
                    {25'd0, rid, rresp, rlast},
                    {25'd0, id, resp, got == n - 1});
                if (got == 0) c0 = c;
                cl = c;
                got++;
            end else if (rvalid) begin
                stalled = 1'b1;
                hd = rdata;
                hl = rlast;
            end
            @(negedge aclk);
        end
        rready = 1'b0;
        chk({tag, "_beats"}, got, n);
        chk({tag, "_rvalid_drop"}, {31'd0, rvalid}, 32'd0);
        if (rpat == 4'hF)
            chk({tag, "_back_to_back"}, cl - c0, n - 1);
    endtask

    initial begin
        aresetn = 1'b0;
        arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0;
        arlock = '0; arcache = '0; arprot = '0; arvalid = 1'b0;
        awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0;
        awlock = '0; awcache = '0; awprot = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0;
        rready = 1'b0; bready = 1'b0;

        repeat (2) @(negedge aclk);
        chk("rst_valids",
            {26'd0, arready, awready, wready, rvalid, rlast, bvalid}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_ids", {20'd0, rid, bid, rresp, bresp}, 32'd0);
        aresetn = 1'b1;
        @(negedge aclk);
        chk("post_rst",
            {26'd0, arready, awready, wready, rvalid, rlast, bvalid},
            32'b110000);

        // INCR write then read back
        aw_send(4'd3, 32'h100, 8'd3, 3'd2, 2'b01);
        for (int i = 0; i < 4; i++)
            w_send(32'hA0 + i, 4'hF, i == 3);
        b_get("t2_b", 4'd3, 2'b00);
        ar_send(4'd9, 32'h100, 8'd3, 3'd2, 2'b01);
        for (int i = 0; i < 4; i++) ev[i] = 32'hA0 + i;
        r_get("t2_r", 4, 4'd9, 2'b00, 4'hF);

        // back-pressure 1,0,0,1
        ar_send(4'd1, 32'h100, 8'd3, 3'd2, 2'b01);
        r_get("t3_stall", 4, 4'd1, 2'b00, 4'b1001);

        // WRAP legal and illegal length
        ar_send(4'd2, 32'h108, 8'd3, 3'd2, 2'b10);
        ev[0] = 32'hA2; ev[1] = 32'hA3; ev[2] = 32'hA0; ev[3] = 32'hA1;
        r_get("t4_wrap", 4, 4'd2, 2'b00, 4'hF);
        ar_send(4'd2, 32'h100, 8'd2, 3'd2, 2'b10);
        ev[0] = 32'hA0; ev[1] = 32'hA1; ev[2] = 32'hA2;
        r_get("t4_badwrap", 3, 4'd2, 2'b10, 4'hF);

        // byte strobes
        aw_send(4'd4, 32'h200, 8'd0, 3'd2, 2'b01);
        w_send(32'hDEADBEEF, 4'hF, 1'b1);
        b_get("t5_full", 4'd4, 2'b00);
        aw_send(4'd4, 32'h200, 8'd0, 3'd2, 2'b01);
        w_send(32'h00005500, 4'b0010, 1'b1);
        b_get("t5_strb", 4'd4, 2'b00);
        ar_send(4'd8, 32'h200, 8'd0, 3'd2, 2'b01);
        ev[0] = 32'hDEAD55EF;
        r_get("t5_rd", 1, 4'd8, 2'b00, 4'hF);

        // early wlast
        aw_send(4'd7, 32'h300, 8'd3, 3'd2, 2'b01);
        for (int i = 0; i < 4; i++)
            w_send(32'h11 * i, 4'hF, i == 1);
        b_get("t5_early", 4'd7, 2'b10);

        // concurrent AR and AW to one word
        arid = 4'd5; araddr = 32'h200; arlen = 8'd0;
        arsize = 3'd2; arburst = 2'b01;
        awid = 4'd6; awaddr = 32'h200; awlen = 8'd0;
        awsize = 3'd2; awburst = 2'b01;
        arvalid = 1'b1; awvalid = 1'b1;
        chk("t6_both_ready", {30'd0, arready, awready}, 32'd3);
        @(negedge aclk);
        arvalid = 1'b0; awvalid = 1'b0;
        w_send(32'h12345678, 4'hF, 1'b1);
        ev[0] = 32'hDEAD55EF;
        r_get("t6_old", 1, 4'd5, 2'b00, 4'hF);
        b_get("t6_b", 4'd6, 2'b00);
        ar_send(4'd5, 32'h200, 8'd0, 3'd2, 2'b01);
        ev[0] = 32'h12345678;
        r_get("t6_new", 1, 4'd5, 2'b00, 4'hF);

        // reset mid-burst
        ar_send(4'd1, 32'h100, 8'd7, 3'd2, 2'b01);
        aw_send(4'd1, 32'h400, 8'd3, 3'd2, 2'b01);
        chk("t1_busy", {30'd0, rvalid, wready}, 32'd3);
        #2 aresetn = 1'b0;
        #1;
        chk("t1_rst_drop",
            {26'd0, arready, awready, wready, rvalid, rlast, bvalid}, 32'd0);
        chk("t1_rst_rdata", rdata, 32'd0);
        @(negedge aclk);
        aresetn = 1'b1;
        #1;
        chk("t1_rel_ready", {30'd0, arready, awready}, 32'd0);
        @(negedge aclk);
        chk("t1_after",
            {26'd0, arready, awready, wready, rvalid, rlast, bvalid},
            32'b110000);
        @(negedge aclk);
        chk("t1_quiet", {30'd0, rvalid, bvalid}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
